// File: rtl/width_gearbox_pkg.sv
// Shared definitions for the width gearbox: stream-order encodings and
// small elaboration-time helpers used to size counters and flags.
package width_gearbox_pkg;

  // Stream ordering selector values for the LSB_FIRST parameter.
  localparam logic ORDER_MSB_FIRST = 1'b0;
  localparam logic ORDER_LSB_FIRST = 1'b1;

  // Unsigned minimum of two non-negative integers.
  function automatic int min_u(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Smallest r such that 2**r >= v (same result as $clog2 for v >= 1).
  function automatic int clog2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 << i) < v) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/gearbox_bitbuf.sv
// Residue bit buffer of the width gearbox. Bits are kept in stream order
// with the oldest bit at buf_r[0]; for MSB-first streams the word is
// bit-reversed on the way in and the head is bit-reversed on the way out,
// so the oldest bit lands on the output MSB. Bits above the fill level are
// always zero, which gives the zero padding of partial words for free.
module gearbox_bitbuf
  import width_gearbox_pkg::*;
#(
  parameter int   IN_WIDTH  = 10,
  parameter int   OUT_WIDTH = 4,
  parameter logic LSB_FIRST = ORDER_LSB_FIRST,
  parameter int   BUF_W     = IN_WIDTH + OUT_WIDTH,
  parameter int   CNT_W     = clog2_ceil(BUF_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic [CNT_W-1:0]     cnt,
  input  logic [CNT_W-1:0]     consumed,
  output logic [OUT_WIDTH-1:0] head
);

  logic [IN_WIDTH-1:0] din_ord_s;
  logic [BUF_W-1:0]    ins_s;
  logic [BUF_W-1:0]    buf_next_s;
  logic [BUF_W-1:0]    buf_r;
  logic [CNT_W:0]      offset_s;

  // Put the incoming word into stream order (stream position 0 at bit 0).
  always_comb begin
    din_ord_s = {IN_WIDTH{1'b0}};
    for (int i = 0; i < IN_WIDTH; i++) begin
      din_ord_s[i] = (LSB_FIRST == ORDER_LSB_FIRST) ? data_in[i] : data_in[IN_WIDTH-1-i];
    end
  end

  // Shift out consumed bits and append the new word right after the survivors.
  always_comb begin
    offset_s = {1'b0, cnt} - {1'b0, consumed};
    ins_s    = {{(BUF_W-IN_WIDTH){1'b0}}, din_ord_s} << offset_s;
    if (load) begin
      buf_next_s = (buf_r >> consumed) | ins_s;
    end else begin
      buf_next_s = buf_r >> consumed;
    end
  end

  // Residue buffer register; reset discards everything held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_r <= {BUF_W{1'b0}};
    end else begin
      buf_r <= buf_next_s;
    end
  end

  // Present the oldest OUT_WIDTH stream bits in the configured bit order.
  always_comb begin
    head = {OUT_WIDTH{1'b0}};
    for (int i = 0; i < OUT_WIDTH; i++) begin
      head[i] = (LSB_FIRST == ORDER_LSB_FIRST) ? buf_r[i] : buf_r[OUT_WIDTH-1-i];
    end
  end

endmodule

// File: rtl/width_gearbox.sv
// Bit-exact stream width converter with valid/ready on both sides and
// packet-end flushing. All handshake outputs are derived from registered
// state only, so there is no combinational path from ready_out to ready_in.
module width_gearbox
  import width_gearbox_pkg::*;
#(
  parameter int   IN_WIDTH  = 10,
  parameter int   OUT_WIDTH = 4,
  parameter logic LSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic [IN_WIDTH-1:0]            data_in,
  input  logic                           last_in,
  output logic                           ready_in,
  output logic                           valid_out,
  output logic [OUT_WIDTH-1:0]           data_out,
  output logic                           last_out,
  output logic [$clog2(OUT_WIDTH+1)-1:0] bits_out,
  input  logic                           ready_out
);

  localparam int BUF_W = IN_WIDTH + OUT_WIDTH;
  localparam int CNT_W = clog2_ceil(BUF_W + 1);
  localparam int BO_W  = $clog2(OUT_WIDTH + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             last_pend_r;
  logic [CNT_W:0]   cnt_ext_s;
  logic [CNT_W:0]   cnt_next_s;
  logic [CNT_W-1:0] consumed_s;
  logic             last_pend_next_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // Handshake and output flags from the registered fill level (one extra bit so cnt+IN_WIDTH cannot wrap).
  always_comb begin
    cnt_ext_s = {1'b0, cnt_r};
    ready_in  = !last_pend_r && ((cnt_ext_s + (CNT_W+1)'(IN_WIDTH)) <= (CNT_W+1)'(BUF_W));
    valid_out = (cnt_ext_s >= (CNT_W+1)'(OUT_WIDTH)) ||
                (last_pend_r && (cnt_r != {CNT_W{1'b0}}));
    last_out  = last_pend_r && (cnt_ext_s <= (CNT_W+1)'(OUT_WIDTH));
    if (valid_out) begin
      bits_out = BO_W'(min_u(int'(cnt_r), OUT_WIDTH));
    end else begin
      bits_out = {BO_W{1'b0}};
    end
    in_fire_s  = valid_in && ready_in;
    out_fire_s = valid_out && ready_out;
  end

  // Next fill level and packet-end tracking; a partial flush consumes only the meaningful bits.
  always_comb begin
    if (out_fire_s) begin
      consumed_s = CNT_W'(bits_out);
    end else begin
      consumed_s = {CNT_W{1'b0}};
    end
    if (in_fire_s) begin
      cnt_next_s = cnt_ext_s - {1'b0, consumed_s} + (CNT_W+1)'(IN_WIDTH);
    end else begin
      cnt_next_s = cnt_ext_s - {1'b0, consumed_s};
    end
    if (out_fire_s && last_out) begin
      last_pend_next_s = 1'b0;
    end else if (in_fire_s && last_in) begin
      last_pend_next_s = 1'b1;
    end else begin
      last_pend_next_s = last_pend_r;
    end
  end

  // Fill counter and pending-last flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      last_pend_r <= 1'b0;
    end else begin
      cnt_r       <= CNT_W'(cnt_next_s);
      last_pend_r <= last_pend_next_s;
    end
  end

  gearbox_bitbuf #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .LSB_FIRST(LSB_FIRST),
    .BUF_W    (BUF_W),
    .CNT_W    (CNT_W)
  ) u_bitbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (in_fire_s),
    .data_in (data_in),
    .cnt     (cnt_r),
    .consumed(consumed_s),
    .head    (data_out)
  );

endmodule

// File: tb/tb_width_gearbox.sv
// Bench for width_gearbox: four instances (10->4 LSB, 10->4 MSB, 4->10 LSB,
// 8->8 LSB) share one clock and reset. Expected output words are pushed to
// a scoreboard queue when stimulus is driven and popped when a DUT fires.
module tb_width_gearbox;
  import width_gearbox_pkg::*;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          bits;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic vi [4];
  logic li [4];
  logic ri [4];
  logic vo [4];
  logic lo [4];
  logic ro [4];
  logic [9:0] din0, din1;
  logic [3:0] din2;
  logic [7:0] din3;
  logic [3:0] d0, d1;
  logic [9:0] d2;
  logic [7:0] d3;
  logic [2:0] bo0, bo1;
  logic [3:0] bo2, bo3;
  logic [15:0] dout_w [4];
  logic [3:0]  bo_w [4];

  assign dout_w[0] = 16'(d0);
  assign dout_w[1] = 16'(d1);
  assign dout_w[2] = 16'(d2);
  assign dout_w[3] = 16'(d3);
  assign bo_w[0]   = 4'(bo0);
  assign bo_w[1]   = 4'(bo1);
  assign bo_w[2]   = bo2;
  assign bo_w[3]   = bo3;

  width_gearbox #(.IN_WIDTH(10), .OUT_WIDTH(4), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[0]), .data_in(din0), .last_in(li[0]),
    .ready_in(ri[0]), .valid_out(vo[0]), .data_out(d0), .last_out(lo[0]),
    .bits_out(bo0), .ready_out(ro[0]));
  width_gearbox #(.IN_WIDTH(10), .OUT_WIDTH(4), .LSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[1]), .data_in(din1), .last_in(li[1]),
    .ready_in(ri[1]), .valid_out(vo[1]), .data_out(d1), .last_out(lo[1]),
    .bits_out(bo1), .ready_out(ro[1]));
  width_gearbox #(.IN_WIDTH(4), .OUT_WIDTH(10), .LSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[2]), .data_in(din2), .last_in(li[2]),
    .ready_in(ri[2]), .valid_out(vo[2]), .data_out(d2), .last_out(lo[2]),
    .bits_out(bo2), .ready_out(ro[2]));
  width_gearbox #(.IN_WIDTH(8), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[3]), .data_in(din3), .last_in(li[3]),
    .ready_in(ri[3]), .valid_out(vo[3]), .data_out(d3), .last_out(lo[3]),
    .bits_out(bo3), .ready_out(ro[3]));

  exp_t        sbq [$];
  logic [63:0] acc [4];
  int          acc_n [4];
  logic        pend [4];
  logic        stall_prev [4];
  logic [15:0] prev_d [4];
  logic [3:0]  prev_b [4];
  logic        prev_l [4];
  logic        in_fired [4];
  int          nout [4];
  logic        auto_sb;
  int          total;
  int          bad;

  function automatic int iw_of(input int k);
    case (k)
      0, 1:    return 10;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int ow_of(input int k);
    case (k)
      0, 1:    return 4;
      2:       return 10;
      default: return 8;
    endcase
  endfunction

  function automatic logic lsb_of(input int k);
    return (k != 1);
  endfunction

  function automatic logic [15:0] din_of(input int k);
    case (k)
      0:       return 16'(din0);
      1:       return 16'(din1);
      2:       return 16'(din2);
      default: return 16'(din3);
    endcase
  endfunction

  function automatic int pending(input int k);
    int n;
    n = 0;
    foreach (sbq[i]) if (sbq[i].id == k) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic set_din(input int k, input logic [15:0] w);
    case (k)
      0:       din0 = w[9:0];
      1:       din1 = w[9:0];
      2:       din2 = w[3:0];
      default: din3 = w[7:0];
    endcase
  endtask

  task automatic expect_word(input int k, input logic [15:0] data, input int bits, input logic last);
    exp_t e;
    e.id = k; e.data = data; e.bits = bits; e.last = last;
    sbq.push_back(e);
  endtask

  // Emit the oldest n stream bits of the model accumulator as one expected word.
  task automatic emit(input int k, input int n, input logic lastf);
    exp_t e;
    int ow;
    ow = ow_of(k);
    e.id = k; e.data = 16'h0; e.bits = n; e.last = lastf;
    for (int j = 0; j < n; j++) begin
      if (lsb_of(k)) e.data[j] = acc[k][j];
      else           e.data[ow-1-j] = acc[k][j];
    end
    sbq.push_back(e);
  endtask

  task automatic model_push(input int k, input logic [15:0] w, input logic last);
    int iw, ow;
    iw = iw_of(k);
    ow = ow_of(k);
    for (int i = 0; i < iw; i++) begin
      acc[k][acc_n[k]] = lsb_of(k) ? w[i] : w[iw-1-i];
      acc_n[k]++;
    end
    while (acc_n[k] >= ow) begin
      emit(k, ow, last && (acc_n[k] == ow));
      acc[k] = acc[k] >> ow;
      acc_n[k] -= ow;
    end
    if (last && acc_n[k] > 0) begin
      emit(k, acc_n[k], 1'b1);
      acc[k] = 64'h0;
      acc_n[k] = 0;
    end
    if (last) pend[k] = 1'b1;
  endtask

  task automatic monitor(input int k);
    int iw, ow, fill, idx;
    logic [15:0] m;
    iw = iw_of(k);
    ow = ow_of(k);
    m = 16'((32'd1 << ow) - 1);
    in_fired[k] = 1'b0;
    if (auto_sb) begin
      fill = acc_n[k];
      foreach (sbq[i]) if (sbq[i].id == k) fill += sbq[i].bits;
      chk("ready_in", k, 32'(ri[k]), 32'(!pend[k] && (fill + iw <= iw + ow)));
      chk("valid_out", k, 32'(vo[k]), 32'((fill >= ow) || (pend[k] && fill != 0)));
    end
    if (stall_prev[k]) begin
      chk("hold_valid", k, 32'(vo[k]), 32'd1);
      chk("hold_data", k, 32'(dout_w[k]), 32'(prev_d[k]));
      chk("hold_bits", k, 32'(bo_w[k]), 32'(prev_b[k]));
      chk("hold_last", k, 32'(lo[k]), 32'(prev_l[k]));
    end
    stall_prev[k] = vo[k] && !ro[k];
    prev_d[k] = dout_w[k];
    prev_b[k] = bo_w[k];
    prev_l[k] = lo[k];
    if (vo[k] && ro[k]) begin
      idx = -1;
      for (int i = 0; i < sbq.size(); i++) if (idx < 0 && sbq[i].id == k) idx = i;
      if (idx < 0) begin
        chk("unexpected_out", k, 32'(dout_w[k]), 32'h0001_0000);
      end else begin
        chk("data", k, 32'(dout_w[k] & m), 32'(sbq[idx].data));
        chk("bits", k, 32'(bo_w[k]), 32'(sbq[idx].bits));
        chk("last", k, 32'(lo[k]), 32'(sbq[idx].last));
        if (sbq[idx].last) pend[k] = 1'b0;
        sbq.delete(idx);
        nout[k]++;
      end
    end
    if (vi[k] && ri[k]) begin
      in_fired[k] = 1'b1;
      if (auto_sb) model_push(k, din_of(k), li[k]);
    end
  endtask

  // One clock cycle: observe all DUTs on the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 4; k++) monitor(k);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [15:0] w, input logic last);
    int n;
    set_din(k, w);
    vi[k] = 1'b1;
    li[k] = last;
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_fired[k] && n < 50);
    chk("send_accept", k, 32'(in_fired[k]), 32'd1);
    vi[k] = 1'b0;
    li[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (pending(k) > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", k, 32'(pending(k)), 32'd0);
  endtask

  task automatic reset_all();
    for (int k = 0; k < 4; k++) begin
      vi[k] = 1'b0; li[k] = 1'b0; ro[k] = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sbq.delete();
    for (int k = 0; k < 4; k++) begin
      acc[k] = 64'h0; acc_n[k] = 0; pend[k] = 1'b0; stall_prev[k] = 1'b0;
    end
  endtask

  task automatic check_idle(input int k);
    chk("rst_valid_out", k, 32'(vo[k]), 32'd0);
    chk("rst_bits_out", k, 32'(bo_w[k]), 32'd0);
    chk("rst_last_out", k, 32'(lo[k]), 32'd0);
    chk("rst_data_out", k, 32'(dout_w[k]), 32'd0);
    chk("rst_ready_in", k, 32'(ri[k]), 32'd1);
  endtask

  initial begin
    int nsent, n0;
    logic [15:0] w;
    total = 0;
    bad = 0;
    auto_sb = 1'b0;
    rst_n = 1'b0;
    din0 = 10'h0; din1 = 10'h0; din2 = 4'h0; din3 = 8'h0;
    for (int k = 0; k < 4; k++) begin
      vi[k] = 1'b0; li[k] = 1'b0; ro[k] = 1'b0; nout[k] = 0; in_fired[k] = 1'b0;
    end

    reset_all();
    for (int k = 0; k < 4; k++) check_idle(k);

    // 10->4 LSB first, single last word
    ro[0] = 1'b1;
    expect_word(0, 16'h5, 4, 1'b0);
    expect_word(0, 16'hA, 4, 1'b0);
    expect_word(0, 16'h2, 2, 1'b1);
    send(0, 16'h2A5, 1'b1);
    drain(0);

    // 10->4 MSB first, partial word padded in the low bits
    ro[1] = 1'b1;
    expect_word(1, 16'hA, 4, 1'b0);
    expect_word(1, 16'h9, 4, 1'b0);
    expect_word(1, 16'h4, 2, 1'b1);
    send(1, 16'h2A5, 1'b1);
    drain(1);

    // 4->10 LSB first, packet of four nibbles
    ro[2] = 1'b1;
    expect_word(2, 16'h321, 10, 1'b0);
    expect_word(2, 16'h010, 6, 1'b1);
    send(2, 16'h1, 1'b0);
    send(2, 16'h2, 1'b0);
    send(2, 16'h3, 1'b0);
    send(2, 16'h4, 1'b1);
    drain(2);

    // 10->4 continuous input with a 5-cycle downstream stall
    auto_sb = 1'b1;
    nsent = 0;
    w = 16'($urandom_range(0, 1023));
    for (int c = 0; c < 60; c++) begin
      ro[0] = !(c >= 10 && c < 15);
      if (nsent < 12) begin
        set_din(0, w);
        vi[0] = 1'b1;
        li[0] = (nsent == 11);
      end else begin
        vi[0] = 1'b0;
        li[0] = 1'b0;
      end
      tick();
      if (in_fired[0]) begin
        nsent++;
        w = 16'($urandom_range(0, 1023));
      end
    end
    vi[0] = 1'b0;
    li[0] = 1'b0;
    ro[0] = 1'b1;
    drain(0);
    chk("stall_words_sent", 0, 32'(nsent), 32'd12);

    // 8->8 back-to-back: accepted every cycle, one output per cycle after one cycle
    ro[3] = 1'b1;
    n0 = nout[3];
    for (int i = 0; i < 16; i++) begin
      set_din(3, 16'($urandom_range(0, 255)));
      vi[3] = 1'b1;
      li[3] = (i == 15);
      tick();
      chk("b2b_accept", 3, 32'(in_fired[3]), 32'd1);
      chk("b2b_outcount", 3, 32'(nout[3] - n0), 32'(i));
    end
    vi[3] = 1'b0;
    li[3] = 1'b0;
    tick();
    chk("b2b_outcount_end", 3, 32'(nout[3] - n0), 32'd16);
    drain(3);

    // Reset mid-packet with six bits buffered, then a fresh packet
    ro[0] = 1'b0;
    send(0, 16'h3FF, 1'b0);
    ro[0] = 1'b1;
    tick();
    ro[0] = 1'b0;
    reset_all();
    check_idle(0);
    auto_sb = 1'b0;
    ro[0] = 1'b1;
    expect_word(0, 16'h5, 4, 1'b0);
    expect_word(0, 16'hA, 4, 1'b0);
    expect_word(0, 16'h2, 2, 1'b1);
    send(0, 16'h2A5, 1'b1);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
